// File: rtl/train_score_accumulator.sv
// train_score_accumulator
// Scores one pass over the sample set for each phase the data-loader enables.
// In the CC phase it counts correct classifications (pred == label). In the ERR
// phase it builds a saturating sum of |err|. After exactly N_SAMPLES accepted
// results it pulses done for one cycle, then holds the totals for readout until
// both enables are low.
module train_score_accumulator #(
    parameter int N_SAMPLES = 150,
    parameter int LABEL_W   = 2,
    parameter int ERR_W     = 16,
    parameter int ACC_W     = 24,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_cc,
    input  logic               en_err,
    input  logic               clear,
    input  logic               smp_valid,
    input  logic [LABEL_W-1:0] pred,
    input  logic [LABEL_W-1:0] label,
    input  logic [ERR_W-1:0]   err,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   smp_cnt,
    output logic [CNT_W-1:0]   correct_cnt,
    output logic [ACC_W-1:0]   err_acc,
    output logic               err_sat
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CC   = 2'b01,
        ERR  = 2'b10,
        HOLD = 2'b11
    } state_t;

    // The magnitude needs one more bit than err, so the most-negative value is
    // represented exactly. The sum is wide enough for either operand, plus a carry.
    localparam int MAG_W = ERR_W + 1;
    localparam int SUM_W = ((ACC_W > MAG_W) ? ACC_W : MAG_W) + 1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [SUM_W-1:0] ACC_MAX_EXT = SUM_W'(ACC_MAX);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   smp_next;
    logic [CNT_W-1:0]   correct_next;
    logic [ACC_W-1:0]   acc_next;
    logic               sat_next;
    logic               done_next;
    logic               busy_next;

    logic [MAG_W-1:0]   err_ext;
    logic [MAG_W-1:0]   err_mag;
    logic [SUM_W-1:0]   err_sum;
    logic               sum_over;
    logic               last_smp;
    logic               hit;

    // Absolute value of the signed error and the candidate accumulator sum
    always_comb begin
        err_ext  = {err[ERR_W-1], err};
        err_mag  = err[ERR_W-1] ? (~err_ext + MAG_W'(1)) : err_ext;
        err_sum  = SUM_W'(err_acc) + SUM_W'(err_mag);
        sum_over = (err_sum > ACC_MAX_EXT);
        last_smp = (smp_cnt == LAST_IDX);
        hit      = (pred == label);
    end

    // Next-state and next-output logic; clear overrides every state
    always_comb begin
        state_next   = state;
        smp_next     = smp_cnt;
        correct_next = correct_cnt;
        acc_next     = err_acc;
        sat_next     = err_sat;
        done_next    = 1'b0;

        if (clear) begin
            state_next   = IDLE;
            smp_next     = '0;
            correct_next = '0;
            acc_next     = '0;
            sat_next     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_cc) begin
                        state_next   = CC;
                        smp_next     = '0;
                        correct_next = '0;
                    end else if (en_err) begin
                        state_next = ERR;
                        smp_next   = '0;
                        acc_next   = '0;
                        sat_next   = 1'b0;
                    end
                end

                CC: begin
                    if (!en_cc) begin
                        state_next = IDLE;
                    end else if (smp_valid) begin
                        smp_next = smp_cnt + CNT_W'(1);
                        if (hit) begin
                            correct_next = correct_cnt + CNT_W'(1);
                        end
                        if (last_smp) begin
                            state_next = HOLD;
                            done_next  = 1'b1;
                        end
                    end
                end

                ERR: begin
                    if (!en_err) begin
                        state_next = IDLE;
                    end else if (smp_valid) begin
                        smp_next = smp_cnt + CNT_W'(1);
                        if (sum_over) begin
                            acc_next = ACC_MAX;
                            sat_next = 1'b1;
                        end else begin
                            acc_next = err_sum[ACC_W-1:0];
                        end
                        if (last_smp) begin
                            state_next = HOLD;
                            done_next  = 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (!en_cc && !en_err) begin
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        busy_next = (state_next == CC) || (state_next == ERR);
    end

    // State and output registers, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            smp_cnt     <= '0;
            correct_cnt <= '0;
            err_acc     <= '0;
            err_sat     <= 1'b0;
        end else begin
            state       <= state_next;
            busy        <= busy_next;
            done        <= done_next;
            smp_cnt     <= smp_next;
            correct_cnt <= correct_next;
            err_acc     <= acc_next;
            err_sat     <= sat_next;
        end
    end

endmodule

// File: tb/tb_train_score_accumulator.sv
// tb_train_score_accumulator
// Directed sequence of scoring passes with randomized gaps and data. Expected
// totals come from plain arithmetic over the samples driven. A second instance
// with a 10-bit accumulator shares the inputs so that saturation can be observed.
module tb_train_score_accumulator;

    localparam int  N       = 150;
    localparam int  LABEL_W = 2;
    localparam int  ERR_W   = 16;
    localparam int  CNT_W   = 8;
    localparam int  ACC_W   = 24;
    localparam int  ACC_W_S = 10;
    localparam longint MAX_L = (64'd1 << ACC_W) - 1;
    localparam longint MAX_S = (64'd1 << ACC_W_S) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en_cc = 1'b0;
    logic               en_err = 1'b0;
    logic               clear = 1'b0;
    logic               smp_valid = 1'b0;
    logic [LABEL_W-1:0] pred = '0;
    logic [LABEL_W-1:0] label = '0;
    logic [ERR_W-1:0]   err = '0;

    logic               busy, done, err_sat;
    logic [CNT_W-1:0]   smp_cnt, correct_cnt;
    logic [ACC_W-1:0]   err_acc;

    logic               s_busy, s_done, s_err_sat;
    logic [CNT_W-1:0]   s_smp_cnt, s_correct_cnt;
    logic [ACC_W_S-1:0] s_err_acc;

    int checks = 0;
    int failures = 0;

    longint exp_acc, exp_acc_s;
    logic   exp_sat, exp_sat_s;
    int     exp_smp, exp_correct;

    train_score_accumulator #(
        .N_SAMPLES(N), .LABEL_W(LABEL_W), .ERR_W(ERR_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .en_cc(en_cc), .en_err(en_err), .clear(clear),
        .smp_valid(smp_valid), .pred(pred), .label(label), .err(err),
        .busy(busy), .done(done), .smp_cnt(smp_cnt), .correct_cnt(correct_cnt),
        .err_acc(err_acc), .err_sat(err_sat)
    );

    train_score_accumulator #(
        .N_SAMPLES(N), .LABEL_W(LABEL_W), .ERR_W(ERR_W), .ACC_W(ACC_W_S), .CNT_W(CNT_W)
    ) dut_small (
        .clk(clk), .rst(rst), .en_cc(en_cc), .en_err(en_err), .clear(clear),
        .smp_valid(smp_valid), .pred(pred), .label(label), .err(err),
        .busy(s_busy), .done(s_done), .smp_cnt(s_smp_cnt), .correct_cnt(s_correct_cnt),
        .err_acc(s_err_acc), .err_sat(s_err_sat)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint abs_err(input logic [ERR_W-1:0] e);
        longint v;
        v = longint'($signed(e));
        return (v < 0) ? -v : v;
    endfunction

    // Random idle gap of 0..2 cycles with junk data, then one accepted sample
    task automatic apply_stimulus(input logic [LABEL_W-1:0] p, input logic [LABEL_W-1:0] l,
                                  input logic [ERR_W-1:0] e);
        int gap;
        gap = int'($urandom_range(0, 2));
        repeat (gap) begin
            smp_valid = 1'b0;
            pred  = LABEL_W'($urandom);
            label = LABEL_W'($urandom);
            err   = ERR_W'($urandom);
            cycle();
        end
        smp_valid = 1'b1;
        pred  = p;
        label = l;
        err   = e;
        cycle();
        smp_valid = 1'b0;
    endtask

    // Fold one ERR-phase sample into both accumulator models
    task automatic model_err(input logic [ERR_W-1:0] e);
        exp_smp++;
        if (exp_acc + abs_err(e) > MAX_L) begin
            exp_acc = MAX_L;
            exp_sat = 1'b1;
        end else begin
            exp_acc = exp_acc + abs_err(e);
        end
        if (exp_acc_s + abs_err(e) > MAX_S) begin
            exp_acc_s = MAX_S;
            exp_sat_s = 1'b1;
        end else begin
            exp_acc_s = exp_acc_s + abs_err(e);
        end
    endtask

    task automatic start_err_pass();
        en_err = 1'b1;
        cycle();
        exp_smp   = 0;
        exp_acc   = 0;
        exp_acc_s = 0;
        exp_sat   = 1'b0;
        exp_sat_s = 1'b0;
    endtask

    task automatic end_pass();
        en_cc  = 1'b0;
        en_err = 1'b0;
        cycle();
    endtask

    initial begin
        logic [LABEL_W-1:0] p;
        logic [LABEL_W-1:0] l;
        logic [ERR_W-1:0]   e;

        // Reset state
        #3;
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_smp_cnt", smp_cnt, 0);
        check_output("rst_correct_cnt", correct_cnt, 0);
        check_output("rst_err_acc", err_acc, 0);
        check_output("rst_err_sat", err_sat, 0);
        @(negedge clk);
        rst = 1'b1;
        cycle();

        // smp_valid in IDLE is ignored
        apply_stimulus(2'd1, 2'd1, 16'd5);
        check_output("idle_smp_ignored", smp_cnt, 0);
        check_output("idle_not_busy", busy, 0);

        // CC pass: matches on even indices only
        $display("[TB] CC pass, even-index matches");
        en_cc = 1'b1;
        cycle();
        check_output("cc_busy", busy, 1);
        exp_smp = 0;
        exp_correct = 0;
        for (int i = 0; i < N; i++) begin
            p = LABEL_W'($urandom);
            l = (i % 2 == 0) ? p : (p ^ LABEL_W'($urandom_range(1, 3)));
            apply_stimulus(p, l, ERR_W'($urandom));
            exp_smp++;
            if (p == l) exp_correct++;
            if (i < N - 1) begin
                check_output("cc_no_early_done", done, 0);
                check_output("cc_smp_cnt", smp_cnt, exp_smp);
            end
        end
        check_output("cc_done_pulse", done, 1);
        check_output("cc_final_smp", smp_cnt, N);
        check_output("cc_final_correct", correct_cnt, exp_correct);
        check_output("cc_correct_is_half", correct_cnt, 75);
        check_output("cc_hold_not_busy", busy, 0);
        check_output("cc_small_done", s_done, 1);
        check_output("cc_small_correct", s_correct_cnt, exp_correct);

        // HOLD with en_cc still high: no restart, outputs frozen
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(2'd2, 2'd2, 16'd7);
            check_output("hold_done_low", done, 0);
            check_output("hold_smp_frozen", smp_cnt, N);
            check_output("hold_correct_frozen", correct_cnt, exp_correct);
            check_output("hold_not_busy", busy, 0);
        end
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        en_cc = 1'b0;
        check_output("clr_smp_cnt", smp_cnt, 0);
        check_output("clr_correct_cnt", correct_cnt, 0);
        check_output("clr_done", done, 0);
        check_output("clr_busy", busy, 0);
        check_output("clr_err_acc", err_acc, 0);
        cycle();
        check_output("clr_stays_idle", busy, 0);

        // ERR pass, err = -3 on every sample
        $display("[TB] ERR pass, constant -3");
        start_err_pass();
        check_output("err_busy", busy, 1);
        for (int i = 0; i < N; i++) begin
            e = -16'sd3;
            apply_stimulus(LABEL_W'($urandom), LABEL_W'($urandom), e);
            model_err(e);
        end
        check_output("err_m3_acc", err_acc, exp_acc);
        check_output("err_m3_acc_value", err_acc, 450);
        check_output("err_m3_sat", err_sat, exp_sat);
        check_output("err_m3_done", done, 1);
        check_output("err_m3_smp", smp_cnt, N);
        check_output("err_m3_small_acc", s_err_acc, exp_acc_s);
        end_pass();
        check_output("err_m3_back_idle", busy, 0);

        // ERR pass, most-negative error once then zeros
        $display("[TB] ERR pass, most-negative error");
        start_err_pass();
        for (int i = 0; i < N; i++) begin
            e = (i == 0) ? 16'h8000 : 16'h0000;
            apply_stimulus(LABEL_W'($urandom), LABEL_W'($urandom), e);
            model_err(e);
        end
        check_output("err_min_acc", err_acc, exp_acc);
        check_output("err_min_acc_value", err_acc, 32768);
        check_output("err_min_sat", err_sat, 0);
        check_output("err_min_small_acc", s_err_acc, exp_acc_s);
        check_output("err_min_small_sat", s_err_sat, exp_sat_s);
        end_pass();

        // ERR pass, +100 on every sample: the 10-bit copy saturates at sample 11
        $display("[TB] ERR pass, saturation");
        start_err_pass();
        check_output("sat_cleared_on_entry", s_err_sat, 0);
        for (int i = 0; i < N; i++) begin
            e = 16'd100;
            apply_stimulus(LABEL_W'($urandom), LABEL_W'($urandom), e);
            model_err(e);
            check_output("sat_small_acc", s_err_acc, exp_acc_s);
            check_output("sat_small_flag", s_err_sat, exp_sat_s);
            check_output("sat_flag_from_11", s_err_sat, (i + 1 >= 11) ? 1 : 0);
        end
        check_output("sat_main_acc", err_acc, exp_acc);
        check_output("sat_main_flag", err_sat, 0);
        check_output("sat_small_smp", s_smp_cnt, N);
        end_pass();

        // ERR pass with random errors
        $display("[TB] ERR pass, random errors");
        start_err_pass();
        for (int i = 0; i < N; i++) begin
            e = ERR_W'($urandom);
            apply_stimulus(LABEL_W'($urandom), LABEL_W'($urandom), e);
            model_err(e);
        end
        check_output("rnd_acc", err_acc, exp_acc);
        check_output("rnd_sat", err_sat, exp_sat);
        check_output("rnd_small_acc", s_err_acc, exp_acc_s);
        check_output("rnd_small_sat", s_err_sat, exp_sat_s);
        check_output("rnd_done", done, 1);
        end_pass();

        // Both enables from IDLE: CC wins; abort after 20 samples
        $display("[TB] CC priority and abort");
        en_cc  = 1'b1;
        en_err = 1'b1;
        cycle();
        check_output("both_busy", busy, 1);
        check_output("both_smp_zero", smp_cnt, 0);
        check_output("both_err_acc_kept", err_acc, exp_acc);
        exp_smp = 0;
        exp_correct = 0;
        for (int i = 0; i < 20; i++) begin
            en_err = 1'($urandom);
            p = LABEL_W'($urandom);
            l = LABEL_W'($urandom);
            apply_stimulus(p, l, ERR_W'($urandom));
            exp_smp++;
            if (p == l) exp_correct++;
        end
        check_output("abort_pre_smp", smp_cnt, 20);
        check_output("abort_pre_correct", correct_cnt, exp_correct);
        check_output("abort_pre_err_acc", err_acc, exp_acc);
        en_cc = 1'b0;
        en_err = 1'b0;
        smp_valid = 1'b1;
        pred = 2'd3;
        label = 2'd3;
        cycle();
        smp_valid = 1'b0;
        check_output("abort_idle", busy, 0);
        check_output("abort_smp_kept", smp_cnt, 20);
        check_output("abort_correct_kept", correct_cnt, exp_correct);
        check_output("abort_no_done", done, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_output("abort_done_stays_low", done, 0);
        end

        // Asynchronous reset mid-ERR at smp_cnt = 37
        $display("[TB] Async reset mid-pass");
        start_err_pass();
        for (int i = 0; i < 37; i++) begin
            e = ERR_W'($urandom);
            apply_stimulus(LABEL_W'($urandom), LABEL_W'($urandom), e);
            model_err(e);
        end
        check_output("arst_pre_smp", smp_cnt, 37);
        #2;
        rst = 1'b0;
        #1;
        check_output("arst_busy", busy, 0);
        check_output("arst_done", done, 0);
        check_output("arst_smp", smp_cnt, 0);
        check_output("arst_correct", correct_cnt, 0);
        check_output("arst_acc", err_acc, 0);
        check_output("arst_sat", err_sat, 0);
        #2;
        rst = 1'b1;
        start_err_pass();
        check_output("arst_restart_busy", busy, 1);
        for (int i = 0; i < N; i++) begin
            e = ERR_W'($urandom);
            apply_stimulus(LABEL_W'($urandom), LABEL_W'($urandom), e);
            model_err(e);
        end
        check_output("arst_pass_done", done, 1);
        check_output("arst_pass_smp", smp_cnt, N);
        check_output("arst_pass_acc", err_acc, exp_acc);
        check_output("arst_pass_small_acc", s_err_acc, exp_acc_s);
        cycle();
        check_output("arst_pass_done_one_cycle", done, 0);
        end_pass();
        check_output("final_idle", s_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
